// File: rtl/cs_rst_pkg.sv
// Shared types and helpers for the cs reset sequencer.
package cs_rst_pkg;

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_HOLD_ALL  = 3'd1,
        S_REL_DEV   = 3'd2,
        S_RUN       = 3'd3,
        S_HOLD_DEV  = 3'd4
    } state_e;

    // Counter width large enough to hold the longest of the three intervals.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cs_sync2.sv
// Two-flop synchronizer for asynchronous single-bit status inputs.
module cs_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/cs_rst_ctrl.sv
// Reset sequencer: waits for stable PLL lock, releases rst_all then rst_dev,
// and services soft full/device reset requests.
module cs_rst_ctrl
    import cs_rst_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = 256,
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned DEV_DELAY   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    input  logic cmd_rst_all,
    input  logic cmd_rst_dev,
    output logic rst_all,
    output logic rst_dev,
    output logic busy,
    output logic rst_done
);

    localparam int unsigned CW = cnt_width(LOCK_CYCLES, RST_CYCLES, DEV_DELAY);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] DEV_LAST  = CW'(DEV_DELAY - 1);

    logic lock_s;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rst_all_q, rst_all_d;
    logic          rst_dev_q, rst_dev_d;
    logic          busy_q, busy_d;
    logic          rst_done_q, rst_done_d;

    cs_sync2 #(.RST_VAL(1'b0)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_WAIT_LOCK: begin
                if (!lock_s)                 cnt_d   = '0;
                else if (cnt_q == LOCK_LAST) state_d = S_REL_DEV;
                else                         cnt_d   = cnt_q + CW'(1);
            end
            S_HOLD_ALL: begin
                if (cnt_q == RST_LAST) state_d = S_REL_DEV;
                else                   cnt_d   = cnt_q + CW'(1);
            end
            S_REL_DEV: begin
                if (cmd_rst_all)            state_d = S_HOLD_ALL;
                else if (cnt_q == DEV_LAST) state_d = S_RUN;
                else                        cnt_d   = cnt_q + CW'(1);
            end
            S_RUN: begin
                if (cmd_rst_all)      state_d = S_HOLD_ALL;
                else if (cmd_rst_dev) state_d = S_HOLD_DEV;
            end
            S_HOLD_DEV: begin
                if (cmd_rst_all)            state_d = S_HOLD_ALL;
                else if (cnt_q == RST_LAST) state_d = S_RUN;
                else                        cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = S_WAIT_LOCK;
        endcase

        // Losing lock overrides every command and count.
        if (!lock_s && (state_q != S_WAIT_LOCK)) state_d = S_WAIT_LOCK;

        if (state_d != state_q) cnt_d = '0;

        rst_all_d  = (state_d == S_WAIT_LOCK) || (state_d == S_HOLD_ALL);
        rst_dev_d  = (state_d != S_RUN);
        busy_d     = (state_d != S_RUN);
        rst_done_d = (state_d == S_RUN) && (state_q != S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT_LOCK;
            cnt_q      <= '0;
            rst_all_q  <= 1'b1;
            rst_dev_q  <= 1'b1;
            busy_q     <= 1'b1;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_all_q  <= rst_all_d;
            rst_dev_q  <= rst_dev_d;
            busy_q     <= busy_d;
            rst_done_q <= rst_done_d;
        end
    end

    assign rst_all  = rst_all_q;
    assign rst_dev  = rst_dev_q;
    assign busy     = busy_q;
    assign rst_done = rst_done_q;

endmodule

// File: tb/tb_cs_rst_ctrl.sv
// Bench for cs_rst_ctrl: directed scenarios plus random traffic against a
// countdown-based reference model.
module tb_cs_rst_ctrl;

    localparam int unsigned LOCK_CYCLES = 4;
    localparam int unsigned RST_CYCLES  = 3;
    localparam int unsigned DEV_DELAY   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pll_lock = 1'b0;
    logic cmd_rst_all = 1'b0;
    logic cmd_rst_dev = 1'b0;
    logic rst_all, rst_dev, busy, rst_done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: lock history plus remaining-high countdowns per reset.
    bit m_ls1, m_ls2;
    bit m_waiting;
    int m_streak;
    int m_all_left;
    int m_dev_left;
    bit m_prev_dev;
    bit e_all, e_dev, e_done;

    cs_rst_ctrl #(
        .LOCK_CYCLES (LOCK_CYCLES),
        .RST_CYCLES  (RST_CYCLES),
        .DEV_DELAY   (DEV_DELAY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .cmd_rst_all (cmd_rst_all),
        .cmd_rst_dev (cmd_rst_dev),
        .rst_all     (rst_all),
        .rst_dev     (rst_dev),
        .busy        (busy),
        .rst_done    (rst_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ls1 = 1'b0;
        m_ls2 = 1'b0;
        m_waiting = 1'b1;
        m_streak = 0;
        m_all_left = 0;
        m_dev_left = 0;
        m_prev_dev = 1'b1;
        e_all = 1'b1;
        e_dev = 1'b1;
        e_done = 1'b0;
    endtask

    task automatic model_edge(input bit lk, input bit ca, input bit cd);
        bit lock_s;
        lock_s = m_ls2;
        if (!lock_s && !m_waiting) begin
            m_waiting = 1'b1;
            m_streak = 0;
            m_all_left = 0;
            m_dev_left = 0;
        end else if (m_waiting) begin
            if (lock_s) begin
                m_streak++;
                if (m_streak == int'(LOCK_CYCLES)) begin
                    m_waiting = 1'b0;
                    m_dev_left = DEV_DELAY;
                end
            end else begin
                m_streak = 0;
            end
        end else if (m_all_left > 0) begin
            m_all_left--;
            if (m_all_left == 0) m_dev_left = DEV_DELAY;
        end else if (m_dev_left > 0) begin
            if (ca) begin
                m_all_left = RST_CYCLES;
                m_dev_left = 0;
            end else begin
                m_dev_left--;
            end
        end else begin
            if (ca)      m_all_left = RST_CYCLES;
            else if (cd) m_dev_left = RST_CYCLES;
        end
        m_ls2 = m_ls1;
        m_ls1 = lk;
        e_all  = m_waiting || (m_all_left > 0);
        e_dev  = e_all || (m_dev_left > 0);
        e_done = m_prev_dev && !e_dev;
        m_prev_dev = e_dev;
    endtask

    task automatic compare_outputs();
        chk("rst_all", 32'(rst_all), 32'(e_all));
        chk("rst_dev", 32'(rst_dev), 32'(e_dev));
        chk("busy", 32'(busy), 32'(e_dev));
        chk("rst_done", 32'(rst_done), 32'(e_done));
        chk("order", 32'(rst_all && !rst_dev), 32'd0);
    endtask

    // Drive one cycle of inputs (called at posedge+1), advance model at the edge, check at edge+1.
    task automatic cycle(input bit lk, input bit ca, input bit cd);
        pll_lock = lk;
        cmd_rst_all = ca;
        cmd_rst_dev = cd;
        @(posedge clk);
        if (rst_n) model_edge(lk, ca, cd);
        #1;
        compare_outputs();
    endtask

    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_all", 32'(rst_all), 32'd1);
        chk("async_dev", 32'(rst_dev), 32'd1);
        chk("async_busy", 32'(busy), 32'd1);
        chk("async_done", 32'(rst_done), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        compare_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_outputs();
        rst_n = 1'b1;

        // Power-up with steady lock.
        repeat (20) cycle(1'b1, 1'b0, 1'b0);

        // Lock glitch during the lock wait.
        async_reset();
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        repeat (16) cycle(1'b1, 1'b0, 1'b0);

        // Soft device reset, soft full reset, both together.
        cycle(1'b1, 1'b0, 1'b1);
        repeat (6) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (8) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (8) cycle(1'b1, 1'b0, 1'b0);

        // Device request during full hold, full request during device hold and release.
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        repeat (6) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (8) cycle(1'b1, 1'b0, 1'b0);

        // Lock loss in run, then recovery.
        repeat (5) cycle(1'b0, 1'b0, 1'b0);
        repeat (16) cycle(1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a soft reset.
        cycle(1'b1, 1'b1, 1'b0);
        async_reset();
        repeat (16) cycle(1'b1, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit lk, ca, cd;
            lk = ($urandom_range(0, 79) != 0);
            ca = ($urandom_range(0, 11) == 0);
            cd = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) async_reset();
            else cycle(lk, ca, cd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
